// File: rtl/commit_pkg.sv
// Shared types and constants for the commit stage: record layout, popcount helper, arbiter modes.
package commit_pkg;

   localparam int unsigned NUM_THREADS  = 4;
   localparam int unsigned NUM_WARPS    = 4;
   localparam int unsigned NW_BITS      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
   localparam int unsigned XLEN         = 32;
   localparam int unsigned NR_BITS      = 6;
   localparam int unsigned UUID_WIDTH   = 44;
   localparam int unsigned COMMIT_SIZEW = $clog2(NUM_THREADS + 1);

   localparam string ARB_RR   = "R";
   localparam string ARB_PRIO = "P";

   typedef struct packed {
      logic [UUID_WIDTH-1:0]                uuid;
      logic [NW_BITS-1:0]                   wid;
      logic [NUM_THREADS-1:0]               tmask;
      logic [XLEN-1:0]                      pc;
      logic                                 wb;
      logic [NR_BITS-1:0]                   rd;
      logic [NUM_THREADS-1:0][XLEN-1:0]     data;
      logic                                 sop;
      logic                                 eop;
   } commit_data_t;

   // Number of active threads in a mask.
   function automatic logic [COMMIT_SIZEW-1:0] popcount(input logic [NUM_THREADS-1:0] mask);
      logic [COMMIT_SIZEW-1:0] n;
      n = '0;
      for (int i = 0; i < int'(NUM_THREADS); i++) begin
         n = n + COMMIT_SIZEW'(mask[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/commit_if.sv
// Commit-source and writeback handshake bundle between execute units, commit stage and writeback.
interface commit_if #(
   parameter int unsigned NUM_INPUTS = 4
);
   import commit_pkg::*;

   logic [NUM_INPUTS-1:0]    in_valid;
   logic [NUM_INPUTS-1:0]    in_ready;
   commit_data_t [NUM_INPUTS-1:0] in_data;
   logic                     wb_valid;
   logic                     wb_ready;
   commit_data_t             wb_data;

   modport slave (
      input  in_valid, in_data, wb_ready,
      output in_ready, wb_valid, wb_data
   );

   modport master (
      output in_valid, in_data, wb_ready,
      input  in_ready, wb_valid, wb_data
   );

endinterface

// File: rtl/commit_arbiter.sv
// One-hot grant among requesting commit sources: round-robin with a rotating pointer, or fixed priority.
module commit_arbiter
   import commit_pkg::*;
#(
   parameter int unsigned NUM_INPUTS = 4,
   parameter string       ARBITER    = ARB_RR
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NUM_INPUTS-1:0] i_req,
   output logic [NUM_INPUTS-1:0] o_grant_c
);

   localparam int unsigned IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

   logic [IDX_W-1:0] r_ptr;
   logic [IDX_W-1:0] w_ptr_next;

   function automatic int unsigned wrap_idx(input int unsigned base, input int unsigned off);
      return (base + off) % NUM_INPUTS;
   endfunction

   // Descending scan so the lowest-ranked requester is the last (winning) assignment.
   always_comb begin
      o_grant_c  = '0;
      w_ptr_next = r_ptr;
      if (ARBITER == ARB_PRIO) begin
         for (int i = int'(NUM_INPUTS) - 1; i >= 0; i--) begin
            if (i_req[i]) begin
               o_grant_c = NUM_INPUTS'(1) << i;
            end
         end
      end else begin
         for (int k = int'(NUM_INPUTS) - 1; k >= 0; k--) begin
            if (i_req[wrap_idx(32'(r_ptr), 32'(k))]) begin
               o_grant_c  = NUM_INPUTS'(1) << wrap_idx(32'(r_ptr), 32'(k));
               w_ptr_next = IDX_W'(wrap_idx(32'(r_ptr), 32'(k + 1)));
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ptr <= '0;
      end else begin
         r_ptr <= w_ptr_next;
      end
   end

endmodule

// File: rtl/commit_unit.sv
// Commit stage: arbitrates commit sources into a retire FIFO, drives a backpressured writeback
// port, and tracks retired thread-instructions plus per-warp end-of-packet commit pulses.
module commit_unit
   import commit_pkg::*;
#(
   parameter int unsigned NUM_INPUTS    = 4,
   parameter int unsigned PERF_CTR_BITS = 44,
   parameter string       ARBITER       = ARB_RR,
   parameter int unsigned BUF_DEPTH     = 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   commit_if.slave                  bus,
   output logic [PERF_CTR_BITS-1:0] instret,
   output logic                     committed,
   output logic [NW_BITS-1:0]       committed_wid
);

   localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
   localparam int unsigned SUM_W = PERF_CTR_BITS + 1;

   logic [NUM_INPUTS-1:0]    w_req;
   logic [NUM_INPUTS-1:0]    w_grant;
   logic                     w_can_accept;
   logic                     w_push;
   logic                     w_pop;
   logic                     w_head_valid;
   commit_data_t             w_in_rec;
   commit_data_t             w_head;
   logic [SUM_W-1:0]         w_inst_sum;
   logic [PERF_CTR_BITS-1:0] w_inst_next;

   commit_data_t             r_mem [BUF_DEPTH];
   logic [PTR_W-1:0]         r_head;
   logic [PTR_W-1:0]         r_tail;
   logic [CNT_W-1:0]         r_count;
   logic [PERF_CTR_BITS-1:0] r_instret;
   logic                     r_committed;
   logic [NW_BITS-1:0]       r_committed_wid;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Grants depend only on registered occupancy, never on wb_ready; none while in reset.
   assign w_can_accept = reset_n && (r_count < CNT_W'(BUF_DEPTH));
   assign w_req        = w_can_accept ? bus.in_valid : '0;

   commit_arbiter #(
      .NUM_INPUTS (NUM_INPUTS),
      .ARBITER    (ARBITER)
   ) u_arb (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_req     (w_req),
      .o_grant_c (w_grant)
   );

   assign bus.in_ready = w_grant;
   assign w_push       = |w_grant;

   always_comb begin
      w_in_rec = '0;
      for (int i = 0; i < int'(NUM_INPUTS); i++) begin
         if (w_grant[i]) begin
            w_in_rec = bus.in_data[i];
         end
      end
   end

   // Records without writeback retire regardless of wb_ready.
   assign w_head_valid = (r_count != '0);
   assign w_head       = r_mem[r_head];
   assign w_pop        = w_head_valid && (!w_head.wb || bus.wb_ready);
   assign bus.wb_valid = w_head_valid && w_head.wb;
   assign bus.wb_data  = w_head;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         for (int i = 0; i < int'(BUF_DEPTH); i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_mem[r_tail] <= w_in_rec;
            r_tail        <= ptr_inc(r_tail);
         end
         if (w_pop) begin
            r_head <= ptr_inc(r_head);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

   // One extra sum bit detects overflow so the counter pins at all-ones.
   assign w_inst_sum  = {1'b0, r_instret} + SUM_W'(popcount(w_head.tmask));
   assign w_inst_next = w_inst_sum[PERF_CTR_BITS] ? '1 : w_inst_sum[PERF_CTR_BITS-1:0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_instret       <= '0;
         r_committed     <= 1'b0;
         r_committed_wid <= '0;
      end else begin
         r_committed <= w_pop && w_head.eop;
         if (w_pop) begin
            r_instret       <= w_inst_next;
            r_committed_wid <= w_head.wid;
         end
      end
   end

   assign instret       = r_instret;
   assign committed     = r_committed;
   assign committed_wid = r_committed_wid;

endmodule
